regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the single 8x32 register-file write port among three requesters: ALU, ID and MEM (load return).
- Drives the register file's w_addr, w_enable, w_select, w_alu and w_other through one registered output stage.
- Keeps a per-register scoreboard of outstanding writes so issue logic can stall reads on pending destinations.

Parameters:
- NREG, 8, number of architectural registers; fixes address width at 3.
- DW, 32, data width.
- CW, 2, width of each scoreboard counter; maximum outstanding writes per register is 2^CW-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid/id_valid/mem_valid  in  1 each  write request
- alu_ready/id_ready/mem_ready  out  1 each  grant, combinational
- alu_addr/id_addr/mem_addr  in  3 each  destination register
- alu_data/id_data/mem_data  in  32 each  write data
- rsv_valid  in  1  reserve destination at issue
- rsv_addr  in  3  register to reserve
- rsv_ready  out  1  reservation accepted
- rd_addr_0, rd_addr_1  in  3 each  issue-stage read addresses
- rd_busy_0, rd_busy_1  out  1 each  register has an outstanding write
- w_addr  out  3  to register file
- w_enable  out  1  to register file
- w_select  out  1  0 = ALU data, 1 = other data
- w_alu, w_other  out  32 each  to register file
- sb_err  out  1  sticky: commit to an unreserved register

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - w_enable=0, w_addr=0, w_select=0, w_alu=0, w_other=0.
  - All counters 0; sb_err=0.
  - Round-robin pointer last=MEM, so ALU has first priority after reset.
- Handshake:
  - Transfer occurs when valid && ready.
  - A requester holds valid, addr and data stable until ready.
  - ready depends on the valid inputs only; at most one ready is high per cycle.
- Arbitration:
  - Round-robin over indices 0=ALU, 1=ID, 2=MEM.
  - Search starts at last+1 (mod 3).
  - last updates to the granted index on each transfer; it is unchanged when nothing is granted.
- Throughput: one grant per cycle; no bubbles under back-to-back requests.
- Latency:
  - A transfer in cycle N drives w_enable=1 in cycle N+1 with the registered addr and data.
  - The register file commits at the end of N+1.
  - Grants nothing in a cycle: w_enable=0 in the next cycle; w_addr, w_alu and w_other hold their last values.
- Data routing:
  - ALU grant: w_select=0, w_alu=data.
  - ID or MEM grant: w_select=1, w_other=data.
  - The unused data output holds its previous value.
- Scoreboard:
  - One CW-bit counter per register.
  - rsv_ready = (cnt[rsv_addr] != max).
  - Reservation (rsv_valid && rsv_ready) increments cnt[rsv_addr].
  - Commit (w_enable in a cycle) decrements cnt[w_addr] at the end of that cycle.
  - Reservation and commit to the same register in the same cycle: the counter is unchanged.
  - Reservation and commit to different registers in the same cycle: both apply.
  - Commit when cnt=0: counter stays 0 (no underflow) and sb_err sets; sb_err clears only on rst.
  - rd_busy_k = (cnt[rd_addr_k] != 0), combinational.
- Reset mid-operation: an in-flight output-stage write is dropped, w_enable drops immediately and all reservations are lost.

Optional Feature:
- Macro: REGFILE_WR_ARBITER_BYPASS_EN.
- When defined:
  - Adds outputs rd_fwd_0 and rd_fwd_1 (1 bit each) and fwd_data (32 bits).
  - rd_fwd_k=1 when w_enable && w_addr==rd_addr_k && cnt[rd_addr_k]==1.
  - Under that condition rd_busy_k is forced to 0.
  - fwd_data = (w_select ? w_other : w_alu).
- When undefined:
  - These ports do not exist.
  - rd_busy_k is exactly cnt != 0.

Decomposition:
- Shared package (regfile_pkg), contents:
  - Constants NREG=8, AW=3, DW=32.
  - Requester index enum: REQ_ALU=0, REQ_ID=1, REQ_MEM=2.
  - W_SEL_ALU=0, W_SEL_OTHER=1.
- One natural sub-module: rr_arbiter3, the round-robin grant plus last-pointer register.
- Scoreboard counters stay inline.

Test Plan:
- Reset priority: after rst, all three valid with addresses 1/2/3 and data A/B/C held. Grants go ALU, ID, MEM over 3 consecutive cycles. w_enable is high for cycles 2-4 with w_select 0,1,1 and w_addr 1,2,3.
- Round-robin resume: ALU valid alone, then ALU and MEM valid together. Next grant is MEM, then ALU.
- Scoreboard: reserve r5 twice, then a third reserve on r5. After 2 reservations cnt=2; rd_busy_0=1 for rd_addr_0=5. The third reserve sees rsv_ready=1 and brings cnt to 3; a fourth sees rsv_ready=0. Three ALU commits to r5 return cnt to 0 and rd_busy_0 to 0.
- Simultaneous events: reservation of r4 in the same cycle as the commit to r4 leaves cnt unchanged. Commit to r6 with cnt=0 sets sb_err=1, and sb_err persists.
- Async reset: assert rst mid-cycle while w_enable=1. w_enable drops without waiting for a clock edge, counters read 0 and ALU priority is restored.
- Bypass (macro defined): cnt[r2]=1, MEM write 0xDEAD_BEEF to r2 in its w_enable cycle with rd_addr_1=2. Expect rd_fwd_1=1, rd_busy_1=0 and fwd_data=0xDEADBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 2;
    localparam int unsigned NREQ = 3;

    // Requester indices, also the round-robin order
    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_ID  = 2'd1,
        REQ_MEM = 2'd2
    } req_idx_e;

    localparam logic W_SEL_ALU   = 1'b0;
    localparam logic W_SEL_OTHER = 1'b1;

    // One write request payload
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter; the search starts just after the last winner.
module rr_arbiter3
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt_c,
    output req_idx_e        gnt_idx_c
);

    req_idx_e last_q;
    req_idx_e last_d;

    // Nearest requester after last wins; last only moves on a grant
    always_comb begin
        logic        found;
        int unsigned idx;
        gnt_c     = '0;
        gnt_idx_c = REQ_ALU;
        last_d    = last_q;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && req[2'(idx)]) begin
                found            = 1'b1;
                gnt_c[2'(idx)]   = 1'b1;
                gnt_idx_c        = req_idx_e'(2'(idx));
            end
        end
        if (found) begin
            last_d = gnt_idx_c;
        end
    end

    // Last-winner pointer; reset leaves MEM as last so ALU goes first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter with per-register outstanding-write scoreboard.
// Optional forwarding of the in-flight write: define REGFILE_WR_ARBITER_BYPASS_EN.
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic          id_valid,
    input  logic          mem_valid,
    output logic          alu_ready,
    output logic          id_ready,
    output logic          mem_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [AW-1:0] id_addr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] alu_data,
    input  logic [DW-1:0] id_data,
    input  logic [DW-1:0] mem_data,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    output logic          rsv_ready,
    input  logic [AW-1:0] rd_addr_0,
    input  logic [AW-1:0] rd_addr_1,
    output logic          rd_busy_0,
    output logic          rd_busy_1,
`ifdef REGFILE_WR_ARBITER_BYPASS_EN
    output logic          rd_fwd_0,
    output logic          rd_fwd_1,
    output logic [DW-1:0] fwd_data,
`endif
    output logic [AW-1:0] w_addr,
    output logic          w_enable,
    output logic          w_select,
    output logic [DW-1:0] w_alu,
    output logic [DW-1:0] w_other,
    output logic          sb_err
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt_c;
    req_idx_e        gnt_idx_c;
    wr_req_t         sel_pl;

    logic            w_enable_q, w_enable_d;
    logic [AW-1:0]   w_addr_q,   w_addr_d;
    logic            w_select_q, w_select_d;
    logic [DW-1:0]   w_alu_q,    w_alu_d;
    logic [DW-1:0]   w_other_q,  w_other_d;

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            sb_err_q, sb_err_d;
    logic            rsv_fire;

    assign req = {mem_valid, id_valid, alu_valid};

    rr_arbiter3 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    assign alu_ready = gnt_c[REQ_ALU];
    assign id_ready  = gnt_c[REQ_ID];
    assign mem_ready = gnt_c[REQ_MEM];

    // Payload of the granted requester
    always_comb begin
        sel_pl = '{addr: alu_addr, data: alu_data};
        case (gnt_idx_c)
            REQ_ID:  sel_pl = '{addr: id_addr,  data: id_data};
            REQ_MEM: sel_pl = '{addr: mem_addr, data: mem_data};
            default: sel_pl = '{addr: alu_addr, data: alu_data};
        endcase
    end

    // Output stage next state; unused data lane and address hold when idle
    always_comb begin
        w_enable_d = |gnt_c;
        w_addr_d   = w_addr_q;
        w_select_d = w_select_q;
        w_alu_d    = w_alu_q;
        w_other_d  = w_other_q;
        if (|gnt_c) begin
            w_addr_d = sel_pl.addr;
            if (gnt_idx_c == REQ_ALU) begin
                w_select_d = W_SEL_ALU;
                w_alu_d    = sel_pl.data;
            end else begin
                w_select_d = W_SEL_OTHER;
                w_other_d  = sel_pl.data;
            end
        end
    end

    // Output stage registers; reset drops any in-flight write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_enable_q <= 1'b0;
            w_addr_q   <= '0;
            w_select_q <= W_SEL_ALU;
            w_alu_q    <= '0;
            w_other_q  <= '0;
        end else begin
            w_enable_q <= w_enable_d;
            w_addr_q   <= w_addr_d;
            w_select_q <= w_select_d;
            w_alu_q    <= w_alu_d;
            w_other_q  <= w_other_d;
        end
    end

    assign w_enable = w_enable_q;
    assign w_addr   = w_addr_q;
    assign w_select = w_select_q;
    assign w_alu    = w_alu_q;
    assign w_other  = w_other_q;

    assign rsv_ready = (cnt_q[rsv_addr] != CNT_MAX);
    assign rsv_fire  = rsv_valid && rsv_ready;

    // Scoreboard update: reserve increments, commit decrements, same-register pair cancels
    always_comb begin
        sb_err_d = sb_err_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc      = rsv_fire && (rsv_addr == AW'(r));
            dec      = w_enable_q && (w_addr_q == AW'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
            end
        end
    end

    // Scoreboard counters and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

`ifdef REGFILE_WR_ARBITER_BYPASS_EN
    // A read whose only pending write is committing now can take the data directly
    assign rd_fwd_0  = w_enable_q && (w_addr_q == rd_addr_0) && (cnt_q[rd_addr_0] == CW'(1));
    assign rd_fwd_1  = w_enable_q && (w_addr_q == rd_addr_1) && (cnt_q[rd_addr_1] == CW'(1));
    assign rd_busy_0 = (cnt_q[rd_addr_0] != '0) && !rd_fwd_0;
    assign rd_busy_1 = (cnt_q[rd_addr_1] != '0) && !rd_fwd_1;
    assign fwd_data  = (w_select_q == W_SEL_OTHER) ? w_other_q : w_alu_q;
`else
    assign rd_busy_0 = (cnt_q[rd_addr_0] != '0);
    assign rd_busy_1 = (cnt_q[rd_addr_1] != '0);
`endif

endmodule
